// File: rtl/sort_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
package sort_pkg;

    typedef enum logic [0:0] {
        SORT_IDLE = 1'b0,
        SORT_RUN  = 1'b1
    } sort_state_e;

    localparam logic ORDER_ASC  = 1'b0;
    localparam logic ORDER_DESC = 1'b1;

    // Phase counter width: clog2(n), never narrower than one bit.
    function automatic int unsigned phase_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Start/done handshake and data bus of the sorter.
interface sort_engine_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
);
    logic             start;
    logic             descending;
    logic [N*W-1:0]   unsorted_flat;
    logic [N*W-1:0]   sorted_flat;
    logic             busy;
    logic             done;
    logic             start_display;

    modport master (
        output start, descending, unsorted_flat,
        input  sorted_flat, busy, done, start_display
    );

    modport slave (
        input  start, descending, unsorted_flat,
        output sorted_flat, busy, done, start_display
    );
endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange of one adjacent pair; lo feeds the lower slot.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         descending,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    // Strict compare keeps equal values in place, which makes the sort stable.
    always_comb begin
        swapped = (descending == ORDER_DESC) ? (a < b) : (a > b);
        lo      = swapped ? b : a;
        hi      = swapped ? a : b;
    end

endmodule

// File: rtl/sort_engine.sv
// Multi-cycle odd-even transposition sorter, one phase per clock.
// Optional build macro SORT_EARLY_EXIT_EN: stop after two consecutive swap-free phases.
module sort_engine
    import sort_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic          clk,
    input  logic          rst,
    sort_engine_if.slave  bus
);

    localparam int unsigned PW        = phase_w(N);
    localparam int unsigned NUM_EVEN  = N / 2;
    localparam int unsigned NUM_ODD   = (N - 1) / 2;
    localparam int unsigned NUM_ODD_A = (NUM_ODD == 0) ? 1 : NUM_ODD;

    sort_state_e     state_q, state_d;
    logic [W-1:0]    arr_q [N];
    logic [W-1:0]    arr_d [N];
    logic [W-1:0]    phase_arr [N];
    logic [PW-1:0]   phase_q, phase_d;
    logic            desc_q, desc_d;
    logic [N*W-1:0]  sorted_q, sorted_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            disp_q, disp_d;
    logic            last_phase;

    logic [W-1:0]         even_lo [NUM_EVEN];
    logic [W-1:0]         even_hi [NUM_EVEN];
    logic [NUM_EVEN-1:0]  even_sw;
    logic [W-1:0]         odd_lo [NUM_ODD_A];
    logic [W-1:0]         odd_hi [NUM_ODD_A];
    logic [NUM_ODD_A-1:0] odd_sw;

    // Even-phase comparators on pairs (0,1), (2,3), ...
    for (genvar i = 0; i < NUM_EVEN; i++) begin : g_even
        sort_cmp_swap #(.W(W)) u_cmp (
            .a          (arr_q[2*i]),
            .b          (arr_q[2*i+1]),
            .descending (desc_q),
            .lo         (even_lo[i]),
            .hi         (even_hi[i]),
            .swapped    (even_sw[i])
        );
    end

    // Odd-phase comparators on pairs (1,2), (3,4), ...
    if (NUM_ODD > 0) begin : g_odd
        for (genvar i = 0; i < NUM_ODD; i++) begin : g_pair
            sort_cmp_swap #(.W(W)) u_cmp (
                .a          (arr_q[2*i+1]),
                .b          (arr_q[2*i+2]),
                .descending (desc_q),
                .lo         (odd_lo[i]),
                .hi         (odd_hi[i]),
                .swapped    (odd_sw[i])
            );
        end
    end else begin : g_no_odd
        assign odd_lo[0] = '0;
        assign odd_hi[0] = '0;
        assign odd_sw    = '0;
    end

    // Array after the current phase; unpaired end elements pass through.
    always_comb begin
        phase_arr = arr_q;
        if (!phase_q[0]) begin
            for (int i = 0; i < NUM_EVEN; i++) begin
                phase_arr[2*i]   = even_lo[i];
                phase_arr[2*i+1] = even_hi[i];
            end
        end else begin
            for (int i = 0; i < NUM_ODD; i++) begin
                phase_arr[2*i+1] = odd_lo[i];
                phase_arr[2*i+2] = odd_hi[i];
            end
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    logic any_swap;
    logic prev_swap_q, prev_swap_d;

    // Terminate on the last phase or after two consecutive swap-free phases.
    always_comb begin
        any_swap    = phase_q[0] ? (|odd_sw) : (|even_sw);
        prev_swap_d = (state_q == SORT_RUN) ? any_swap : 1'b0;
        last_phase  = (phase_q == PW'(N - 1)) ||
                      ((phase_q != '0) && !any_swap && !prev_swap_q);
    end

    // Swap flag of the previous phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_swap_q <= 1'b0;
        end else begin
            prev_swap_q <= prev_swap_d;
        end
    end
`else
    logic sw_unused;
    assign sw_unused = ^{even_sw, odd_sw};

    // Fixed latency: always run all N phases.
    always_comb begin
        last_phase = (phase_q == PW'(N - 1));
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SORT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SORT_IDLE: if (bus.start)  state_d = SORT_RUN;
            SORT_RUN:  if (last_phase) state_d = SORT_IDLE;
            default:   state_d = SORT_IDLE;
        endcase
    end

    // Datapath and output register next values.
    always_comb begin
        arr_d    = arr_q;
        phase_d  = phase_q;
        desc_d   = desc_q;
        sorted_d = sorted_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        disp_d   = disp_q;
        case (state_q)
            SORT_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < N; i++) begin
                        arr_d[i] = bus.unsorted_flat[i*W +: W];
                    end
                    desc_d  = (bus.descending == ORDER_DESC);
                    phase_d = '0;
                    busy_d  = 1'b1;
                end
            end
            SORT_RUN: begin
                arr_d   = phase_arr;
                phase_d = phase_q + PW'(1);
                if (last_phase) begin
                    for (int i = 0; i < N; i++) begin
                        sorted_d[i*W +: W] = phase_arr[i];
                    end
                    phase_d = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    disp_d  = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Array, phase counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                arr_q[i] <= '0;
            end
            phase_q  <= '0;
            desc_q   <= 1'b0;
            sorted_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            disp_q   <= 1'b0;
        end else begin
            arr_q    <= arr_d;
            phase_q  <= phase_d;
            desc_q   <= desc_d;
            sorted_q <= sorted_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            disp_q   <= disp_d;
        end
    end

    assign bus.sorted_flat   = sorted_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.start_display = disp_q;

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: N=4/W=4 directed table plus N=7/W=8 randomized vs reference sort.
module tb_sort_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sort_engine_if #(.N(4), .W(4)) bus4 ();
    sort_engine_if #(.N(7), .W(8)) bus7 ();

    sort_engine #(.N(4), .W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    sort_engine #(.N(7), .W(8)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

    typedef struct {
        logic [15:0] vin;
        bit          desc;
        logic [15:0] vexp;
        int          lat_ee;
        bit          poke;
    } vec4_t;

    vec4_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] p4(input int a0, input int a1, input int a2, input int a3);
        return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    // Reference sort (insertion sort) over the first n entries.
    function automatic void ref_sort(input int v[8], input int n, input bit desc, output int s[8]);
        int t;
        s = v;
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (s[j-1] < s[j]) : (s[j-1] > s[j])) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end else begin
                    break;
                end
            end
        end
    endfunction

    // Cycles to done under the early-exit rule: stop after two swap-free phases or at phase n-1.
    function automatic int ee_latency(input int v[8], input int n, input bit desc);
        int a[8];
        int t, sw, sw_prev;
        a = v;
        sw_prev = 1;
        for (int p = 0; p < n; p++) begin
            sw = 0;
            for (int i = p % 2; i + 1 < n; i += 2) begin
                if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    sw++;
                end
            end
            if (p >= 1 && sw == 0 && sw_prev == 0) return p + 1;
            sw_prev = sw;
        end
        return n;
    endfunction

    // Issue one sort on the N=4 DUT; returns at the sample point of the done cycle.
    task automatic run4(input string tag, input logic [15:0] vin, input bit desc,
                        input logic [15:0] vexp, input int exp_lat, input bit poke);
        int cnt;
        bit got;
        bus4.unsorted_flat = vin;
        bus4.descending    = desc;
        bus4.start         = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        check({tag, "_busy_on_accept"}, 64'(bus4.busy), 64'(1));
        cnt = 0;
        got = 0;
        while (!got && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            if (bus4.done) begin
                got = 1;
            end else if (poke && cnt == 1) begin
                bus4.unsorted_flat = p4(15, 15, 15, 15);
                bus4.descending    = 1'b1;
                bus4.start         = 1'b1;
            end else if (poke && cnt == 2) begin
                bus4.start = 1'b0;
            end
        end
        bus4.start = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'(1));
        check({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
        check({tag, "_sorted"}, 64'(bus4.sorted_flat), 64'(vexp));
        check({tag, "_busy_at_done"}, 64'(bus4.busy), 64'(0));
        check({tag, "_start_display"}, 64'(bus4.start_display), 64'(1));
    endtask

    // Issue one sort on the N=7 DUT.
    task automatic run7(input logic [55:0] vin, input bit desc, input logic [55:0] vexp, input int exp_lat);
        int cnt;
        bit got;
        bus7.unsorted_flat = vin;
        bus7.descending    = desc;
        bus7.start         = 1'b1;
        @(posedge clk); #1;
        bus7.start = 1'b0;
        cnt = 0;
        got = 0;
        while (!got && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            if (bus7.done) got = 1;
        end
        check("rnd_latency", 64'(cnt), 64'(exp_lat));
        check("rnd_sorted", 64'(bus7.sorted_flat), 64'(vexp));
    endtask

    initial begin
        int exp_lat;
        int done_cnt;

        bus4.start = 1'b0; bus4.descending = 1'b0; bus4.unsorted_flat = '0;
        bus7.start = 1'b0; bus7.descending = 1'b0; bus7.unsorted_flat = '0;

        tbl[0] = '{p4(3, 1, 2, 0), 1'b0, p4(0, 1, 2, 3),    4, 1'b0};
        tbl[1] = '{p4(3, 1, 2, 0), 1'b1, p4(3, 2, 1, 0),    4, 1'b0};
        tbl[2] = '{p4(2, 2, 1, 2), 1'b0, p4(1, 2, 2, 2),    4, 1'b1};
        tbl[3] = '{p4(0, 1, 2, 3), 1'b0, p4(0, 1, 2, 3),    2, 1'b0};
        tbl[4] = '{p4(3, 2, 1, 0), 1'b0, p4(0, 1, 2, 3),    4, 1'b0};
        tbl[5] = '{p4(0, 1, 2, 3), 1'b1, p4(3, 2, 1, 0),    4, 1'b0};
        tbl[6] = '{p4(7, 7, 7, 7), 1'b1, p4(7, 7, 7, 7),    2, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sorted", 64'(bus4.sorted_flat), 64'(0));
        check("rst_busy", 64'(bus4.busy), 64'(0));
        check("rst_done", 64'(bus4.done), 64'(0));
        check("rst_start_display", 64'(bus4.start_display), 64'(0));
        check("rst_sorted7", 64'(bus7.sorted_flat), 64'(0));
        check("rst_busy7", 64'(bus7.busy), 64'(0));
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
`ifdef SORT_EARLY_EXIT_EN
            exp_lat = tbl[i].lat_ee;
`else
            exp_lat = 4;
`endif
            run4($sformatf("tbl%0d", i), tbl[i].vin, tbl[i].desc, tbl[i].vexp, exp_lat, tbl[i].poke);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_done_pulse", i), 64'(bus4.done), 64'(0));
            check($sformatf("tbl%0d_hold", i), 64'(bus4.sorted_flat), 64'(tbl[i].vexp));
            check($sformatf("tbl%0d_idle", i), 64'(bus4.busy), 64'(0));
        end

        // Reset two cycles into a sort: no done, everything back to zero.
        bus4.unsorted_flat = p4(3, 1, 2, 0);
        bus4.descending    = 1'b0;
        bus4.start         = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_sorted", 64'(bus4.sorted_flat), 64'(0));
        check("midrst_busy", 64'(bus4.busy), 64'(0));
        check("midrst_done", 64'(bus4.done), 64'(0));
        check("midrst_start_display", 64'(bus4.start_display), 64'(0));
        done_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus4.done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        run4("after_rst", p4(15, 0, 15, 0), 1'b0, p4(0, 0, 15, 15), 4, 1'b0);
        @(posedge clk); #1;

        // Back-to-back: second start issued in the done cycle of the first.
        run4("b2b_first", p4(3, 2, 1, 0), 1'b0, p4(0, 1, 2, 3), 4, 1'b0);
        run4("b2b_second", p4(1, 3, 0, 2), 1'b0, p4(0, 1, 2, 3), 4, 1'b0);
        @(posedge clk); #1;

        // Randomized N=7, W=8, both orders, mixed value ranges and presorted inputs.
        for (int t = 0; t < 1000; t++) begin
            int v[8];
            int s[8];
            bit d;
            logic [55:0] vin, vexp;
            d = t[0];
            for (int i = 0; i < 8; i++) begin
                v[i] = ((t % 3) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
                if (i == 7) v[i] = 0;
            end
            if ((t % 3) == 2) begin
                ref_sort(v, 7, d, s);
                v = s;
            end
            ref_sort(v, 7, d, s);
            for (int i = 0; i < 7; i++) begin
                vin[i*8 +: 8]  = 8'(v[i]);
                vexp[i*8 +: 8] = 8'(s[i]);
            end
`ifdef SORT_EARLY_EXIT_EN
            exp_lat = ee_latency(v, 7, d);
`else
            exp_lat = 7;
`endif
            run7(vin, d, vexp, exp_lat);
            if ((t % 5) == 0) begin
                @(posedge clk); #1;
            end
        end
        check("rnd_start_display", 64'(bus7.start_display), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // done and busy must never be high together.
    always @(negedge clk) begin
        if (!rst && ((bus4.done && bus4.busy) || (bus7.done && bus7.busy))) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_busy_overlap: got done=1 busy=1 expected not both");
        end
    end

endmodule
